// File: rtl/keypad_scanner.sv
// keypad_scanner
// ----------------------------------------------------------------------------
// Scans a 4x4 matrix keypad and turns it into debounced key events for the
// CPU input stage. One column is driven low per slot of SCAN_DIV clocks, and
// the synchronized row lines are sampled on the last clock of each slot. The
// four column samples form one 16-bit frame. A frame must repeat unchanged
// for DEBOUNCE_SCANS frames before it becomes the debounced key map. A small
// event FSM then turns map changes into one-cycle key strobes. It also
// applies a rollover lockout when two or more keys are held at once.
//
// Ports
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   key_in_y   row sense lines, pulled up, 0 = key closed in the driven column
//   key_out_x  column drive, active-low one-hot, rotates 1110->1101->1011->0111
//   key_code   code of the last accepted key, {col[1:0], row[1:0]}
//   key_valid  one-cycle strobe for a newly accepted key
//   key_down   high while exactly one debounced key is held
//   key_multi  high while two or more debounced keys are held
//   key_map    debounced pressed map, bit index = col*4+row
// ----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_in_y,
  output logic [3:0]  key_out_x,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic        key_multi,
  output logic [15:0] key_map
);

  localparam int                SLOT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_MAX   = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] NO_KEY   = 2'd0;
  localparam logic [1:0] KEY_HELD = 2'd1;
  localparam logic [1:0] MULTI    = 2'd2;

  // Number of pressed keys in a map.
  function automatic logic [4:0] count_keys(input logic [15:0] map);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, map[i]};
    end
    return n;
  endfunction

  // Index of the lowest pressed key. The caller only uses it when exactly
  // one key is pressed.
  function automatic logic [3:0] key_index(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = map[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  logic [3:0]        y_meta_r;
  logic [3:0]        y_sync_r;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [1:0]        col_r;
  logic [3:0]        key_out_x_r;
  logic [15:0]       raw_r;
  logic [15:0]       prev_frame_r;
  logic [3:0]        stable_cnt_r;
  logic [15:0]       key_map_r;
  logic              map_upd_r;
  logic [1:0]        state_r;
  logic [3:0]        key_code_r;
  logic              key_valid_r;
  logic              key_down_r;
  logic              key_multi_r;

  logic              slot_end_s;
  logic              frame_end_s;
  logic [15:0]       frame_s;
  logic [3:0]        stable_next_s;
  logic              map_load_s;
  logic [4:0]        pop_s;
  logic [3:0]        idx_s;
  logic [1:0]        state_n_s;
  logic [3:0]        code_n_s;
  logic              valid_n_s;

  assign key_out_x = key_out_x_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_down  = key_down_r;
  assign key_multi = key_multi_r;
  assign key_map   = key_map_r;

  assign slot_end_s  = (slot_cnt_r == SLOT_LAST);
  assign frame_end_s = slot_end_s && (col_r == 2'd3);

  // Two-flop synchronizer on the row lines. Reset value is "no key" (pulled up).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta_r <= 4'hF;
      y_sync_r <= 4'hF;
    end else begin
      y_meta_r <= key_in_y;
      y_sync_r <= y_meta_r;
    end
  end

  // Slot timer and column rotation. The column advances on the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r  <= {SLOT_W{1'b0}};
      col_r       <= 2'd0;
      key_out_x_r <= 4'b1110;
    end else if (slot_end_s) begin
      slot_cnt_r  <= {SLOT_W{1'b0}};
      col_r       <= col_r + 2'd1;
      key_out_x_r <= {key_out_x_r[2:0], key_out_x_r[3]};
    end else begin
      slot_cnt_r  <= slot_cnt_r + {{(SLOT_W-1){1'b0}}, 1'b1};
    end
  end

  // Current frame with this slot's column replaced by the inverted synchronized rows.
  always_comb begin
    frame_s = raw_r;
    case (col_r)
      2'd0:    frame_s[3:0]   = ~y_sync_r;
      2'd1:    frame_s[7:4]   = ~y_sync_r;
      2'd2:    frame_s[11:8]  = ~y_sync_r;
      2'd3:    frame_s[15:12] = ~y_sync_r;
      default: frame_s        = raw_r;
    endcase
  end

  // Debounce count for the frame that ends on this edge. The count saturates at DEBOUNCE_SCANS.
  always_comb begin
    if (frame_s == prev_frame_r) begin
      if (stable_cnt_r >= DEB_MAX) begin
        stable_next_s = DEB_MAX;
      end else begin
        stable_next_s = stable_cnt_r + 4'd1;
      end
    end else begin
      stable_next_s = 4'd1;
    end
  end

  assign map_load_s = frame_end_s && (stable_next_s == DEB_MAX);

  // Raw frame accumulator, one column written per sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= 16'h0000;
    end else if (slot_end_s) begin
      raw_r <= frame_s;
    end else begin
      raw_r <= raw_r;
    end
  end

  // Frame-end debounce. map_upd_r flags an actual change of the debounced
  // map, so the FSM sees each new map exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame_r <= 16'h0000;
      stable_cnt_r <= 4'd0;
      key_map_r    <= 16'h0000;
      map_upd_r    <= 1'b0;
    end else if (frame_end_s) begin
      prev_frame_r <= frame_s;
      stable_cnt_r <= stable_next_s;
      if (map_load_s && (frame_s != key_map_r)) begin
        key_map_r <= frame_s;
        map_upd_r <= 1'b1;
      end else begin
        map_upd_r <= 1'b0;
      end
    end else begin
      map_upd_r <= 1'b0;
    end
  end

  assign pop_s = count_keys(key_map_r);
  assign idx_s = key_index(key_map_r);

  // Event FSM next state. MULTI is left only through an empty map (rollover lockout).
  always_comb begin
    state_n_s = state_r;
    code_n_s  = key_code_r;
    valid_n_s = 1'b0;
    case (state_r)
      NO_KEY: begin
        if (map_upd_r && (pop_s == 5'd1)) begin
          state_n_s = KEY_HELD;
          code_n_s  = idx_s;
          valid_n_s = 1'b1;
        end else if (map_upd_r && (pop_s >= 5'd2)) begin
          state_n_s = MULTI;
        end else begin
          state_n_s = NO_KEY;
        end
      end
      KEY_HELD: begin
        if (map_upd_r && (pop_s == 5'd0)) begin
          state_n_s = NO_KEY;
        end else if (map_upd_r && (pop_s == 5'd1)) begin
          // The map changed but still holds one key, so it is a different key.
          state_n_s = KEY_HELD;
          code_n_s  = idx_s;
          valid_n_s = 1'b1;
        end else if (map_upd_r) begin
          state_n_s = MULTI;
        end else begin
          state_n_s = KEY_HELD;
        end
      end
      MULTI: begin
        if (map_upd_r && (pop_s == 5'd0)) begin
          state_n_s = NO_KEY;
        end else begin
          state_n_s = MULTI;
        end
      end
      default: begin
        state_n_s = NO_KEY;
      end
    endcase
  end

  // Event FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= NO_KEY;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
      key_multi_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      key_code_r  <= code_n_s;
      key_valid_r <= valid_n_s;
      key_down_r  <= (state_n_s == KEY_HELD);
      key_multi_r <= (state_n_s == MULTI);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=2.
// A behavioural model predicts every output on every cycle. Directed
// scenarios add hand-computed literal expectations.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_in_y;
  logic [3:0]  key_out_x;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        key_multi;
  logic [15:0] key_map;

  logic [15:0] pressed = 16'h0000;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .key_in_y(key_in_y), .key_out_x(key_out_x),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .key_multi(key_multi), .key_map(key_map)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad: row y is pulled low when column x is driven low and key (x,y) is closed.
  always_comb begin
    key_in_y = 4'hF;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        if (!key_out_x[x] && pressed[x*4+y]) key_in_y[y] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  int          edge_cnt = 0;
  logic [15:0] pd1 = 16'h0, pd2 = 16'h0;
  logic [15:0] m_frame = 16'h0, m_prev = 16'h0, m_map = 16'h0;
  int          m_stable = 0;
  bit          m_pend = 1'b0;
  int          m_keys = 0;      // 0 none, 1 single held, 2 multi lockout
  logic [3:0]  m_code = 4'h0;
  bit          m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_cnt = 0; pd1 = 16'h0; pd2 = 16'h0;
        m_frame = 16'h0; m_prev = 16'h0; m_map = 16'h0;
        m_stable = 0; m_pend = 1'b0; m_keys = 0; m_code = 4'h0; m_valid = 1'b0;
      end else begin
        int n;
        int c;
        edge_cnt++;
        m_valid = 1'b0;
        if (m_pend) begin
          m_pend = 1'b0;
          n = $countones(m_map);
          if (m_keys != 2 && n == 1) begin
            m_keys = 1;
            m_valid = 1'b1;
            for (int i = 0; i < 16; i++) if (m_map[i]) m_code = 4'(i);
          end else if (n == 0) begin
            m_keys = 0;
          end else if (n >= 2) begin
            m_keys = 2;
          end
        end
        // Sample edge: rows seen here were on the pins two clocks earlier.
        if (edge_cnt % SD == 0) begin
          c = ((edge_cnt / SD) - 1) % 4;
          m_frame[c*4 +: 4] = pd2[c*4 +: 4];
          if (c == 3) begin
            if (m_frame == m_prev) m_stable = (m_stable < DEB) ? m_stable + 1 : DEB;
            else m_stable = 1;
            m_prev = m_frame;
            if (m_stable == DEB && m_frame != m_map) begin
              m_map = m_frame;
              m_pend = 1'b1;
            end
          end
        end
        pd2 = pd1;
        pd1 = pressed;
      end
    end
  end

  // ---------------- per-cycle compare + strobe monitor ----------------
  int         strobe_cnt  = 0;
  logic [3:0] last_code   = 4'h0;
  int         strobe_edge = 0;

  initial begin
    forever begin
      logic [29:0] act, exp;
      logic [3:0]  exp_x;
      @(negedge clk);
      exp_x = ~(4'b0001 << ((edge_cnt / SD) % 4));
      exp = {exp_x, m_code, m_valid, (m_keys == 1), (m_keys == 2), m_map};
      act = {key_out_x, key_code, key_valid, key_down, key_multi, key_map};
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL cycle edge=%0d actual=%h required=%h (x,code,valid,down,multi,map)",
                    edge_cnt, act, exp);
      if (key_valid === 1'b1) begin
        strobe_cnt++;
        last_code = key_code;
        strobe_edge = edge_cnt;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    step(3);
    #1 rst_n = 1'b1;
    check("reset_x", 32'(key_out_x), 32'h0000000E);
    check("reset_map", 32'(key_map), 32'h0);

    // 1: idle scanning
    step(1);  check("col0", 32'(key_out_x), 32'hE);
    step(4);  check("col1", 32'(key_out_x), 32'hD);
    step(4);  check("col2", 32'(key_out_x), 32'hB);
    step(4);  check("col3", 32'(key_out_x), 32'h7);
    step(4);  check("col0_wrap", 32'(key_out_x), 32'hE);
    step(47);
    check("idle_strobes", 32'(strobe_cnt), 32'd0);
    check("idle_map", 32'(key_map), 32'h0);

    // 2: key (col2,row1) from edge 64: frames end at 80 and 96, strobe on edge 97
    pressed = 16'h0200;
    step(64);
    check("k9_map", 32'(key_map), 32'h0200);
    check("k9_strobes", 32'(strobe_cnt), 32'd1);
    check("k9_code", 32'(last_code), 32'h9);
    check("k9_edge", 32'(strobe_edge), 32'd97);
    check("k9_down", 32'(key_down), 32'd1);
    pressed = 16'h0000;
    step(64);
    check("k9_rel_down", 32'(key_down), 32'd0);
    check("k9_rel_strobes", 32'(strobe_cnt), 32'd1);

    // 3: bouncing key (col0,row3)
    base = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      step(16);
    end
    check("bounce_none", 32'(strobe_cnt - base), 32'd0);
    pressed = 16'h0008;
    step(64);
    check("bounce_one", 32'(strobe_cnt - base), 32'd1);
    check("bounce_code", 32'(last_code), 32'h3);
    pressed = 16'h0000;
    step(64);

    // 4: rollover lockout
    base = strobe_cnt;
    pressed = 16'h0020;
    step(64);
    check("k5_code", 32'(last_code), 32'h5);
    check("k5_strobes", 32'(strobe_cnt - base), 32'd1);
    pressed = 16'h0420;
    step(64);
    check("multi_on", 32'(key_multi), 32'd1);
    check("multi_code_held", 32'(key_code), 32'h5);
    pressed = 16'h0020;
    step(64);
    check("multi_lock", 32'(key_multi), 32'd1);
    check("multi_no_strobe", 32'(strobe_cnt - base), 32'd1);
    pressed = 16'h0000;
    step(64);
    check("multi_off", 32'({key_multi, key_down}), 32'd0);
    pressed = 16'h0400;
    step(64);
    check("kA_code", 32'(last_code), 32'hA);
    check("kA_strobes", 32'(strobe_cnt - base), 32'd2);
    pressed = 16'h0000;
    step(64);

    // 5: direct key change 1 -> F
    base = strobe_cnt;
    pressed = 16'h0002;
    step(64);
    check("k1_code", 32'(last_code), 32'h1);
    pressed = 16'h8000;
    step(64);
    check("kF_code", 32'(last_code), 32'hF);
    check("kF_strobes", 32'(strobe_cnt - base), 32'd2);
    check("kF_down", 32'(key_down), 32'd1);

    // 6: reset mid-frame while key 6 is held
    pressed = 16'h0040;
    step(64);
    check("k6_code", 32'(last_code), 32'h6);
    step(5);
    #1 rst_n = 1'b0;
    #1;
    check("rst_outs", 32'({key_out_x, key_code, key_valid, key_down, key_multi}), 32'({4'hE, 7'd0}));
    check("rst_map", 32'(key_map), 32'h0);
    step(3);
    #1 rst_n = 1'b1;
    base = strobe_cnt;
    last_code = 4'h0;
    step(40);
    check("k6_again", 32'(strobe_cnt - base), 32'd1);
    check("k6_again_code", 32'(last_code), 32'h6);
    check("k6_again_edge", 32'(strobe_edge), 32'd33);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the external 4x4 matrix keypad (key_out_x column drive, key_in_y row sense) and delivers debounced key events to the CPU core's input stage.
- Sits between the top-level keypad pins and the CPU input register/port logic.
- One 50 MHz clock domain.
- Produces a one-cycle key_valid strobe with a 4-bit key code, plus level status outputs.

Parameters:
- SCAN_DIV, 50000: clock cycles per column slot (1 ms at 50 MHz); legal range >= 2.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required before the stable map updates; legal range 1..15.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_in_y  input  4  row sense lines, pulled up; 0 = the key in the driven column is closed.
- key_out_x  output  4  column drive, active-low one-hot.
- key_code  output  4  code of the last accepted key = {col[1:0], row[1:0]}.
- key_valid  output  1  one-cycle strobe for a new accepted key.
- key_down  output  1  high while exactly one debounced key is held.
- key_multi  output  1  high while two or more debounced keys are held.
- key_map  output  16  debounced pressed map; bit index = col*4+row.

Behaviour:
Reset values:
- key_out_x = 4'b1110; key_code = 0; key_valid = 0; key_down = 0; key_multi = 0; key_map = 0.
- All counters = 0; FSM = NO_KEY.

Scanning:
- slot_cnt counts 0..SCAN_DIV-1.
- On slot_cnt == SCAN_DIV-1, key_in_y is sampled into raw bits col*4+row, taken as inverted rows.
- On the same edge, key_out_x rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- key_in_y is passed through a 2-flop synchronizer before sampling. The synchronizer latency is 2 cycles, which is less than the SCAN_DIV settle time when SCAN_DIV >= 3.
- A frame ends at the col-3 sample edge.

Debounce (evaluated at each frame end):
- If the new raw frame equals the previous raw frame, stable_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stable_cnt = 1.
- When stable_cnt reaches DEBOUNCE_SCANS, key_map <= raw frame on that same edge.
- key_map changes only at frame ends.

Event FSM (evaluated the cycle after key_map updates; registered outputs):
- NO_KEY:
  - popcount(key_map) == 1 -> KEY_HELD; key_valid = 1; key_code = index.
  - popcount(key_map) >= 2 -> MULTI; no strobe.
- KEY_HELD:
  - key_map == 0 -> NO_KEY.
  - Different single key -> stay in KEY_HELD; new strobe; new code.
  - popcount >= 2 -> MULTI; no strobe; key_code held.
- MULTI:
  - Leaves only on key_map == 0 -> NO_KEY. This is the rollover lockout.
  - Dropping back to one key issues no strobe.

Outputs:
- key_down = (state == KEY_HELD).
- key_multi = (state == MULTI).
- key_valid is high for exactly 1 cycle per accepted key. A held key never re-strobes.
- key_code holds until the next strobe.

Boundary cases:
- Press and release within fewer than DEBOUNCE_SCANS frames: no event.
- Bounce that alternates frames restarts stable_cnt.
- Key changes mid-frame: the frame is judged only on its sampled bits.
- rst_n asserted mid-scan: all state returns to reset values immediately, including key_out_x = 1110. After release, scanning restarts at column 0 with slot_cnt 0.
- DEBOUNCE_SCANS = 1: each frame directly updates key_map.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2. A frame is 16 cycles. The bench keypad model pulls row y low when column x is driven low and key (x,y) is closed.

1. Reset, then run with no keys.
   -> key_out_x cycles 1110, 1101, 1011, 0111, each for 4 clks.
   -> key_valid never asserted; key_map = 0.
2. Close key (col 2, row 1) steadily.
   -> key_map = 16'h0200 at the end of the 2nd full frame.
   -> One key_valid pulse with key_code = 4'h9; key_down = 1.
   -> After release, key_down = 0 with no strobe.
3. Toggle key (col 0, row 3) every frame for 6 frames, then hold.
   -> No strobe during toggling.
   -> Exactly one strobe with key_code = 4'h3 after 2 stable frames.
4. Hold key 4'h5, then add key 4'hA.
   -> First a strobe with code 5; then key_multi = 1 with no strobe.
   -> Release 4'hA: still MULTI, no strobe.
   -> Release all: NO_KEY.
   -> Press 4'hA: strobe with code A.
5. Go directly from key 4'h1 to 4'hF between frames.
   -> Two strobes: code 1, then code F; key_down stays 1.
6. Assert rst_n low mid-frame while key 4'h6 is held.
   -> All outputs return to reset values immediately.
   -> After release, a fresh strobe with code 6 follows 2 frames (32 cycles) plus pipeline delay.
